// File: rtl/stage_idex_if.sv
// ID-to-EX bundle: decoded fields coming out of ID and their registered copies
// going to EX and the forwarding unit.
interface stage_idex_if;
   logic [4:0]  IFID_RegisterRs;
   logic [4:0]  IFID_RegisterRt;
   logic [4:0]  IFID_RegisterRd;
   logic [31:0] ID_ReadData1;
   logic [31:0] ID_ReadData2;
   logic [31:0] ID_Imm;
   logic        ID_RegWrite;
   logic        ID_MemRead;
   logic        ID_MemWrite;
   logic        ID_MemToReg;
   logic        ID_RegDst;
   logic        ID_ALUSrc;
   logic [1:0]  ID_ALUOp;

   logic [4:0]  IDEX_RegisterRs;
   logic [4:0]  IDEX_RegisterRt;
   logic [4:0]  IDEX_RegisterRd;
   logic [31:0] IDEX_ReadData1;
   logic [31:0] IDEX_ReadData2;
   logic [31:0] IDEX_Imm;
   logic        IDEX_RegWrite;
   logic        IDEX_MemRead;
   logic        IDEX_MemWrite;
   logic        IDEX_MemToReg;
   logic        IDEX_RegDst;
   logic        IDEX_ALUSrc;
   logic [1:0]  IDEX_ALUOp;
   logic        IDEX_Valid;

   modport master (
      output IFID_RegisterRs, IFID_RegisterRt, IFID_RegisterRd,
             ID_ReadData1, ID_ReadData2, ID_Imm,
             ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg,
             ID_RegDst, ID_ALUSrc, ID_ALUOp,
      input  IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterRd,
             IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm,
             IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg,
             IDEX_RegDst, IDEX_ALUSrc, IDEX_ALUOp, IDEX_Valid
   );

   modport slave (
      input  IFID_RegisterRs, IFID_RegisterRt, IFID_RegisterRd,
             ID_ReadData1, ID_ReadData2, ID_Imm,
             ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg,
             ID_RegDst, ID_ALUSrc, ID_ALUOp,
      output IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterRd,
             IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm,
             IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg,
             IDEX_RegDst, IDEX_ALUSrc, IDEX_ALUOp, IDEX_Valid
   );
endinterface

// File: rtl/stage_idex.sv
// ID/EX pipeline register with load-use hazard detection (one bubble, PC/IFID hold).
// Optional saturating stall counter enabled by defining STAGE_IDEX_STATS_EN.
module stage_idex (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          Flush,
   stage_idex_if.slave   idex,
   output logic          Stall,
   output logic          PCWrite,
   output logic          IFIDWrite
`ifdef STAGE_IDEX_STATS_EN
   ,
   output logic [15:0]   StallCount
`endif
);

   typedef enum logic {BUBBLE = 1'b0, NORMAL = 1'b1} state_t;

   state_t stateReg;
   state_t stateNext;
   logic   loadBubble;

   assign idex.IDEX_Valid = (stateReg == NORMAL);

   // Load-use: the load in EX targets a source of the instruction in ID.
   always_comb begin
      Stall = 1'b0;
      if (!Flush && idex.IDEX_Valid && idex.IDEX_MemRead &&
          (idex.IDEX_RegisterRt != 5'd0) &&
          ((idex.IDEX_RegisterRt == idex.IFID_RegisterRs) ||
           (idex.IDEX_RegisterRt == idex.IFID_RegisterRt)))
         Stall = 1'b1;
   end

   assign PCWrite    = !Stall;
   assign IFIDWrite  = !Stall;
   assign loadBubble = Flush || Stall;

   always_comb begin
      stateNext = NORMAL;
      if (loadBubble)
         stateNext = BUBBLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stateReg <= BUBBLE;
      else
         stateReg <= stateNext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || !rst_n) begin
         idex.IDEX_RegisterRs <= 5'd0;
         idex.IDEX_RegisterRt <= 5'd0;
         idex.IDEX_RegisterRd <= 5'd0;
         idex.IDEX_ReadData1  <= 32'd0;
         idex.IDEX_ReadData2  <= 32'd0;
         idex.IDEX_Imm        <= 32'd0;
         idex.IDEX_RegWrite   <= 1'b0;
         idex.IDEX_MemRead    <= 1'b0;
         idex.IDEX_MemWrite   <= 1'b0;
         idex.IDEX_MemToReg   <= 1'b0;
         idex.IDEX_RegDst     <= 1'b0;
         idex.IDEX_ALUSrc     <= 1'b0;
         idex.IDEX_ALUOp      <= 2'd0;
      end else if (loadBubble) begin
         // A bubble is all-zero so it never writes or reads memory downstream.
         idex.IDEX_RegisterRs <= 5'd0;
         idex.IDEX_RegisterRt <= 5'd0;
         idex.IDEX_RegisterRd <= 5'd0;
         idex.IDEX_ReadData1  <= 32'd0;
         idex.IDEX_ReadData2  <= 32'd0;
         idex.IDEX_Imm        <= 32'd0;
         idex.IDEX_RegWrite   <= 1'b0;
         idex.IDEX_MemRead    <= 1'b0;
         idex.IDEX_MemWrite   <= 1'b0;
         idex.IDEX_MemToReg   <= 1'b0;
         idex.IDEX_RegDst     <= 1'b0;
         idex.IDEX_ALUSrc     <= 1'b0;
         idex.IDEX_ALUOp      <= 2'd0;
      end else begin
         idex.IDEX_RegisterRs <= idex.IFID_RegisterRs;
         idex.IDEX_RegisterRt <= idex.IFID_RegisterRt;
         idex.IDEX_RegisterRd <= idex.IFID_RegisterRd;
         idex.IDEX_ReadData1  <= idex.ID_ReadData1;
         idex.IDEX_ReadData2  <= idex.ID_ReadData2;
         idex.IDEX_Imm        <= idex.ID_Imm;
         idex.IDEX_RegWrite   <= idex.ID_RegWrite;
         idex.IDEX_MemRead    <= idex.ID_MemRead;
         idex.IDEX_MemWrite   <= idex.ID_MemWrite;
         idex.IDEX_MemToReg   <= idex.ID_MemToReg;
         idex.IDEX_RegDst     <= idex.ID_RegDst;
         idex.IDEX_ALUSrc     <= idex.ID_ALUSrc;
         idex.IDEX_ALUOp      <= idex.ID_ALUOp;
      end
   end

`ifdef STAGE_IDEX_STATS_EN
   logic [15:0] stallCountReg;

   // Stall already excludes Flush cycles; saturate rather than wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stallCountReg <= 16'd0;
      else if (Stall && (stallCountReg != 16'hFFFF))
         stallCountReg <= stallCountReg + 16'd1;
   end

   assign StallCount = stallCountReg;
`endif

endmodule

// File: tb/tb_stage_idex.sv
// Directed bench for stage_idex: reset, pass-through, load-use, false-stall,
// flush priority and asynchronous reset during a stall.
module tb_stage_idex;

   logic clk;
   logic rst_n;
   logic Flush;
   logic Stall;
   logic PCWrite;
   logic IFIDWrite;
`ifdef STAGE_IDEX_STATS_EN
   logic [15:0] StallCount;
`endif

   int errors = 0;
   int checks = 0;

   stage_idex_if bus ();

   stage_idex dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Flush     (Flush),
      .idex      (bus),
      .Stall     (Stall),
      .PCWrite   (PCWrite),
      .IFIDWrite (IFIDWrite)
`ifdef STAGE_IDEX_STATS_EN
      ,
      .StallCount(StallCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                         input logic regWrite, input logic memRead, input logic memWrite,
                         input logic memToReg, input logic regDst, input logic aluSrc,
                         input logic [1:0] aluOp);
      bus.IFID_RegisterRs = rs;
      bus.IFID_RegisterRt = rt;
      bus.IFID_RegisterRd = rd;
      bus.ID_ReadData1    = rd1;
      bus.ID_ReadData2    = rd2;
      bus.ID_Imm          = imm;
      bus.ID_RegWrite     = regWrite;
      bus.ID_MemRead      = memRead;
      bus.ID_MemWrite     = memWrite;
      bus.ID_MemToReg     = memToReg;
      bus.ID_RegDst       = regDst;
      bus.ID_ALUSrc       = aluSrc;
      bus.ID_ALUOp        = aluOp;
   endtask

   // lw $rt, imm($rs)
   task automatic set_load(input logic [4:0] rt);
      set_id(5'd2, rt, 5'd0, 32'h0000_1000, 32'h0, 32'h0000_0004,
             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
   endtask

   // add $rd, $rs, $rt
   task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      set_id(rs, rt, rd, 32'h1111_1111, 32'h2222_2222, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      Flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_id(5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                1'($urandom), 1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 2'($urandom));
         edge_sample();
         checks++;
         if ({bus.IDEX_RegisterRs, bus.IDEX_RegisterRt, bus.IDEX_RegisterRd,
              bus.IDEX_ReadData1, bus.IDEX_ReadData2, bus.IDEX_Imm,
              bus.IDEX_RegWrite, bus.IDEX_MemRead, bus.IDEX_MemWrite,
              bus.IDEX_MemToReg, bus.IDEX_RegDst, bus.IDEX_ALUSrc,
              bus.IDEX_ALUOp, bus.IDEX_Valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero IDEX fields rd1=%h valid=%b, required all zero",
                     bus.IDEX_ReadData1, bus.IDEX_Valid);
         end
         checks++;
         if ({Stall, PCWrite, IFIDWrite} !== 3'b011) begin
            errors++;
            $display("FAIL reset_hazard: got Stall/PCWrite/IFIDWrite=%b, required 011",
                     {Stall, PCWrite, IFIDWrite});
         end
      end
`ifdef STAGE_IDEX_STATS_EN
      checks++;
      if (StallCount !== 16'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d required 0", StallCount);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      set_add(5'd3, 5'd4, 5'd5);
      bus.ID_ReadData1 = 32'hCAFE_0001;
      edge_sample();
      checks++;
      if (bus.IDEX_Valid !== 1'b1 || bus.IDEX_ReadData1 !== 32'hCAFE_0001) begin
         errors++;
         $display("FAIL reset_release_capture: got valid=%b rd1=%h, required 1 cafe0001",
                  bus.IDEX_Valid, bus.IDEX_ReadData1);
      end
      $display("reset: released, first edge captured rd1=%h", bus.IDEX_ReadData1);
   endtask

   task automatic test_passthrough();
      @(negedge clk);
      set_id(5'd8, 5'd9, 5'd10, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFF0,
             1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
      edge_sample();
      checks++;
      if (bus.IDEX_ReadData1 !== 32'h1234_5678 || bus.IDEX_RegisterRs !== 5'd8 ||
          bus.IDEX_RegWrite !== 1'b1 || bus.IDEX_Valid !== 1'b1) begin
         errors++;
         $display("FAIL pass_main: got rd1=%h rs=%0d rw=%b v=%b, required 12345678 8 1 1",
                  bus.IDEX_ReadData1, bus.IDEX_RegisterRs, bus.IDEX_RegWrite, bus.IDEX_Valid);
      end
      checks++;
      if ({bus.IDEX_RegisterRt, bus.IDEX_RegisterRd, bus.IDEX_ReadData2, bus.IDEX_Imm,
           bus.IDEX_MemRead, bus.IDEX_MemWrite, bus.IDEX_MemToReg, bus.IDEX_RegDst,
           bus.IDEX_ALUSrc, bus.IDEX_ALUOp} !==
          {5'd9, 5'd10, 32'h9ABC_DEF0, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01}) begin
         errors++;
         $display("FAIL pass_fields: got rt=%0d rd=%0d rd2=%h imm=%h mr=%b mw=%b m2r=%b dst=%b src=%b op=%b, required 9 10 9abcdef0 fffffff0 0 1 0 1 1 01",
                  bus.IDEX_RegisterRt, bus.IDEX_RegisterRd, bus.IDEX_ReadData2, bus.IDEX_Imm,
                  bus.IDEX_MemRead, bus.IDEX_MemWrite, bus.IDEX_MemToReg, bus.IDEX_RegDst,
                  bus.IDEX_ALUSrc, bus.IDEX_ALUOp);
      end
      $display("pass: rd1=%h rs=%0d valid=%b", bus.IDEX_ReadData1, bus.IDEX_RegisterRs, bus.IDEX_Valid);
   endtask

   task automatic test_load_use();
      @(negedge clk);
      set_load(5'd8);
      edge_sample();
      set_add(5'd8, 5'd9, 5'd10);
      #1;
      checks++;
      if ({Stall, PCWrite, IFIDWrite} !== 3'b100) begin
         errors++;
         $display("FAIL loaduse_rs_stall: got Stall/PCWrite/IFIDWrite=%b, required 100",
                  {Stall, PCWrite, IFIDWrite});
      end
      edge_sample();
      checks++;
      if (bus.IDEX_Valid !== 1'b0 || bus.IDEX_RegWrite !== 1'b0 || bus.IDEX_MemRead !== 1'b0 ||
          bus.IDEX_ReadData1 !== 32'd0 || bus.IDEX_RegisterRd !== 5'd0) begin
         errors++;
         $display("FAIL loaduse_bubble: got v=%b rw=%b mr=%b rd1=%h rd=%0d, required all zero",
                  bus.IDEX_Valid, bus.IDEX_RegWrite, bus.IDEX_MemRead, bus.IDEX_ReadData1,
                  bus.IDEX_RegisterRd);
      end
      checks++;
      if (Stall !== 1'b0 || PCWrite !== 1'b1) begin
         errors++;
         $display("FAIL loaduse_release: got Stall=%b PCWrite=%b, required 0 1", Stall, PCWrite);
      end
      edge_sample();
      checks++;
      if (bus.IDEX_Valid !== 1'b1 || bus.IDEX_RegisterRs !== 5'd8 || bus.IDEX_RegisterRd !== 5'd10 ||
          bus.IDEX_ReadData2 !== 32'h2222_2222) begin
         errors++;
         $display("FAIL loaduse_capture: got v=%b rs=%0d rd=%0d rd2=%h, required 1 8 10 22222222",
                  bus.IDEX_Valid, bus.IDEX_RegisterRs, bus.IDEX_RegisterRd, bus.IDEX_ReadData2);
      end
      $display("load-use: add captured after one bubble, rs=%0d", bus.IDEX_RegisterRs);

      // Dependency through the Rt field.
      @(negedge clk);
      set_load(5'd12);
      edge_sample();
      set_add(5'd3, 5'd12, 5'd13);
      #1;
      checks++;
      if (Stall !== 1'b1 || IFIDWrite !== 1'b0) begin
         errors++;
         $display("FAIL loaduse_rt_stall: got Stall=%b IFIDWrite=%b, required 1 0", Stall, IFIDWrite);
      end
      $display("load-use rt: Stall=%b", Stall);
      edge_sample();
   endtask

   task automatic test_no_false_stall();
      @(negedge clk);
      set_load(5'd0);
      edge_sample();
      set_add(5'd0, 5'd0, 5'd1);
      #1;
      checks++;
      if (Stall !== 1'b0 || PCWrite !== 1'b1) begin
         errors++;
         $display("FAIL nostall_zero: got Stall=%b PCWrite=%b, required 0 1", Stall, PCWrite);
      end
      @(negedge clk);
      set_load(5'd8);
      edge_sample();
      set_add(5'd9, 5'd10, 5'd11);
      #1;
      checks++;
      if (Stall !== 1'b0 || IFIDWrite !== 1'b1) begin
         errors++;
         $display("FAIL nostall_nomatch: got Stall=%b IFIDWrite=%b, required 0 1", Stall, IFIDWrite);
      end
      // Non-load producer with a matching source must not stall either.
      edge_sample();
      set_add(5'd10, 5'd10, 5'd4);
      #1;
      checks++;
      if (Stall !== 1'b0) begin
         errors++;
         $display("FAIL nostall_alu: got Stall=%b, required 0", Stall);
      end
      $display("no-false-stall: zero-reg, mismatch and alu producer all Stall=0");
      edge_sample();
   endtask

   task automatic test_flush();
      @(negedge clk);
      set_load(5'd8);
      edge_sample();
      set_add(5'd8, 5'd9, 5'd10);
      Flush = 1'b1;
      #1;
      checks++;
      if ({Stall, PCWrite, IFIDWrite} !== 3'b011) begin
         errors++;
         $display("FAIL flush_priority: got Stall/PCWrite/IFIDWrite=%b, required 011",
                  {Stall, PCWrite, IFIDWrite});
      end
      edge_sample();
      checks++;
      if (bus.IDEX_Valid !== 1'b0 || bus.IDEX_RegWrite !== 1'b0 || bus.IDEX_RegisterRs !== 5'd0) begin
         errors++;
         $display("FAIL flush_bubble: got v=%b rw=%b rs=%0d, required 0 0 0",
                  bus.IDEX_Valid, bus.IDEX_RegWrite, bus.IDEX_RegisterRs);
      end
      Flush = 1'b0;
      set_add(5'd6, 5'd7, 5'd9);
      edge_sample();
      checks++;
      if (bus.IDEX_Valid !== 1'b1 || bus.IDEX_RegisterRd !== 5'd9) begin
         errors++;
         $display("FAIL flush_recover: got v=%b rd=%0d, required 1 9", bus.IDEX_Valid, bus.IDEX_RegisterRd);
      end
      $display("flush: bubble then recovery, rd=%0d", bus.IDEX_RegisterRd);
   endtask

   task automatic test_reset_midstall();
      @(negedge clk);
      set_load(5'd8);
      edge_sample();
      set_add(5'd8, 5'd8, 5'd2);
      #1;
      checks++;
      if (Stall !== 1'b1) begin
         errors++;
         $display("FAIL midstall_setup: got Stall=%b, required 1", Stall);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({Stall, PCWrite, IFIDWrite, bus.IDEX_Valid, bus.IDEX_MemRead, bus.IDEX_RegisterRt} !==
          {3'b011, 1'b0, 1'b0, 5'd0}) begin
         errors++;
         $display("FAIL midstall_reset: got S/PW/IW=%b v=%b mr=%b rt=%0d, required 011 0 0 0",
                  {Stall, PCWrite, IFIDWrite}, bus.IDEX_Valid, bus.IDEX_MemRead, bus.IDEX_RegisterRt);
      end
      $display("reset mid-stall: Stall=%b Valid=%b", Stall, bus.IDEX_Valid);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

`ifdef STAGE_IDEX_STATS_EN
   task automatic one_stall();
      @(negedge clk);
      set_load(5'd8);
      edge_sample();
      set_add(5'd8, 5'd1, 5'd2);
      edge_sample();
      edge_sample();
   endtask

   task automatic test_counter();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) one_stall();
      checks++;
      if (StallCount !== 16'd3) begin
         errors++;
         $display("FAIL count_three: got %0d required 3", StallCount);
      end
      // A flushed hazard is not a stall and is not counted.
      @(negedge clk);
      set_load(5'd8);
      edge_sample();
      set_add(5'd8, 5'd1, 5'd2);
      Flush = 1'b1;
      edge_sample();
      Flush = 1'b0;
      checks++;
      if (StallCount !== 16'd3) begin
         errors++;
         $display("FAIL count_flush: got %0d required 3", StallCount);
      end
      @(negedge clk);
      dut.stallCountReg = 16'hFFFE;
      one_stall();
      one_stall();
      checks++;
      if (StallCount !== 16'hFFFF) begin
         errors++;
         $display("FAIL count_saturate: got %h required ffff", StallCount);
      end
      $display("counter: saturated at %h", StallCount);
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      Flush = 1'b0;
      set_id(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      test_reset();
      test_passthrough();
      test_load_use();
      test_no_false_stall();
      test_flush();
      test_reset_midstall();
`ifdef STAGE_IDEX_STATS_EN
      test_counter();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
